// File: rtl/block_exp_normalize_if.sv
// Stream bus for the block exponent normalizer: raw exponent beats in,
// normalized exponent beats out with the shared block exponent.
interface block_exp_normalize_if #(
    parameter int unsigned EXP_WIDTH = 4,
    parameter int unsigned LANES     = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*EXP_WIDTH-1:0] in_exp;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*EXP_WIDTH-1:0] out_exp;
    logic [EXP_WIDTH-1:0]       out_max_exp;
    logic                       out_last;

    // Environment side: produces input beats, consumes output beats.
    modport master (
        output in_valid, in_exp, out_ready,
        input  in_ready, out_valid, out_exp, out_max_exp, out_last
    );

    // Block side.
    modport slave (
        input  in_valid, in_exp, out_ready,
        output in_ready, out_valid, out_exp, out_max_exp, out_last
    );
endinterface

// File: rtl/block_exp_normalize.sv
// Collects a 64-element block of exponents, finds the shared maximum and
// streams the block back as offset-relative exponents plus the maximum.
module block_exp_normalize #(
    parameter int unsigned EXP_WIDTH = 4,
    parameter int unsigned LANES     = 8
) (
    input logic                  clk,
    input logic                  rst,
    block_exp_normalize_if.slave bus
);
    localparam int unsigned BEATS  = 64 / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_W = LANES * EXP_WIDTH;
    localparam int unsigned T_W    = EXP_WIDTH + 1;
    localparam int unsigned OFS    = 1 << (EXP_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {FILL, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [EXP_WIDTH-1:0] run_max_q, run_max_d, max_q, max_d;
    logic [EXP_WIDTH-1:0] beat_max, new_max;
    logic [BEAT_W-1:0]    out_exp_q, out_exp_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 in_ready_q, in_ready_d;
    logic [BEAT_W-1:0]    buf_q [BEATS];
    logic                 wr_en;
    logic                 in_hs, out_hs;

    // Per lane: zero stays zero, t = e + OFS - max, non-positive t flushes to zero.
    function automatic logic [BEAT_W-1:0] normalize(input logic [BEAT_W-1:0]    beat,
                                                    input logic [EXP_WIDTH-1:0] m);
        logic [T_W-1:0]       t;
        logic [EXP_WIDTH-1:0] e;
        normalize = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            e = beat[EXP_WIDTH*k +: EXP_WIDTH];
            t = {1'b0, e} + T_W'(OFS) - {1'b0, m};
            if (e != '0 && !t[EXP_WIDTH] && t != '0) begin
                normalize[EXP_WIDTH*k +: EXP_WIDTH] = t[EXP_WIDTH-1:0];
            end
        end
    endfunction

    always_comb begin
        beat_max = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (bus.in_exp[EXP_WIDTH*k +: EXP_WIDTH] > beat_max) begin
                beat_max = bus.in_exp[EXP_WIDTH*k +: EXP_WIDTH];
            end
        end
    end

    assign new_max = (beat_max > run_max_q) ? beat_max : run_max_q;
    assign in_hs   = bus.in_valid & in_ready_q;
    assign out_hs  = out_valid_q & bus.out_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state logic; the output beat registers are preloaded one beat ahead.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        max_d       = max_q;
        out_exp_d   = out_exp_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_ready_d  = in_ready_q;
        wr_en       = 1'b0;
        case (state_q)
            FILL: begin
                if (in_hs) begin
                    wr_en     = 1'b1;
                    run_max_d = new_max;
                    cnt_d     = cnt_inc;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d       = '0;
                        max_d       = new_max;
                        state_d     = DRAIN;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_exp_d   = normalize((BEATS == 1) ? bus.in_exp : buf_q[0], new_max);
                        out_last_d  = (BEATS == 1);
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d       = '0;
                        run_max_d   = '0;
                        state_d     = FILL;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_exp_d   = '0;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_exp_d  = normalize(buf_q[cnt_inc], max_q);
                        out_last_d = (cnt_inc == LAST_CNT);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            run_max_q   <= '0;
            max_q       <= '0;
            out_exp_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            max_q       <= max_d;
            out_exp_q   <= out_exp_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Exponent buffer needs no reset: every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[cnt_q] <= bus.in_exp;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_exp     = out_exp_q;
    assign bus.out_max_exp = max_q;
    assign bus.out_last    = out_last_q;
endmodule
